// File: rtl/ov5640_init_pkg.sv
// ----------------------------------------------------------------------------
// ov5640_init_pkg
//   Shared definitions for the OV5640 init-table sequencer.
//   - seq_state_e   : sequencer FSM state encoding
//   - REG_*_MSB/LSB : field positions of {reg_addr[15:0], reg_data[7:0]}
//                     inside one init-table word
//   - us_to_cycles(): elaboration-time microsecond to clock-cycle conversion
// ----------------------------------------------------------------------------
package ov5640_init_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PWR_WAIT,
        FETCH,
        LATCH,
        REQ,
        RST_WAIT,
        NEXT,
        DONE,
        ERROR
    } seq_state_e;

    localparam int REG_ADDR_MSB = 23;
    localparam int REG_ADDR_LSB = 8;
    localparam int REG_DATA_MSB = 7;
    localparam int REG_DATA_LSB = 0;

    // clk_freq_hz must be a whole number of MHz; the top module rejects
    // anything else at elaboration so the integer divide below is exact.
    function automatic int unsigned us_to_cycles(input int unsigned delay_us,
                                                 input int unsigned clk_freq_hz);
        return delay_us * (clk_freq_hz / 32'd1_000_000);
    endfunction

endpackage

// File: rtl/ov5640_delay_timer.sv
// ----------------------------------------------------------------------------
// ov5640_delay_timer
//   One-shot down-counter shared by the power-up and post-reset waits.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     load        : arm the timer with load_val cycles (takes priority)
//     load_val    : wait length in clock cycles
//     run         : high while the owner is waiting; dropping it disarms
//     expired     : one-cycle pulse in the last cycle of the wait
//   A wait of N cycles (N >= 1) gives exactly N cycles with run high, the
//   last of which carries expired. A load_val of 0 behaves like 1.
// ----------------------------------------------------------------------------
module ov5640_delay_timer #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 run,
    output logic                 expired
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 armed_q, armed_d;

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        expired = 1'b0;
        if (load) begin
            armed_d = 1'b1;
            cnt_d   = (load_val == '0) ? '0 : load_val - CNT_WIDTH'(1);
        end else if (!run) begin
            armed_d = 1'b0;
        end else if (armed_q) begin
            if (cnt_q == '0) begin
                expired = 1'b1;
                armed_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/ov5640_init_sequencer.sv
// ----------------------------------------------------------------------------
// ov5640_init_sequencer
//   Walks the OV5640 init register table (entries 0..ROM_DEPTH-1) and issues
//   one SCCB write per entry, with a power-up wait before entry 0 and a
//   settle wait after the software-reset entry.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | out of reset, waiting for start
//   PWR_WAIT | power-up delay before the first write
//   FETCH    | rom_addr = index, ROM read in flight
//   LATCH    | capture rom_q into wr_reg_addr / wr_data
//   REQ      | wr_req held until wr_ack / wr_err; NACK retries stay here
//   RST_WAIT | settle delay after the software-reset entry
//   NEXT     | clear retries, advance index or finish
//   DONE     | all entries written (sticky until next start)
//   ERROR    | retries exhausted; rom_addr holds the failing index
//
//   Ports:
//     clk, reset   : clock, synchronous active-high reset
//     start        : one-cycle pulse, accepted in IDLE/DONE/ERROR only
//     rom_addr     : table index to the ROM
//     rom_q        : registered ROM word, valid one clk after rom_addr
//     wr_req       : SCCB write request, held until wr_ack or wr_err
//     wr_reg_addr  : register address for the write
//     wr_data      : register data for the write
//     wr_ack       : write completed with ACK (pulse)
//     wr_err       : write NACKed (pulse); wins over a coincident wr_ack
//     busy         : sequence in progress
//     done         : all entries written
//     err          : an entry failed after MAX_RETRY re-issues
// ----------------------------------------------------------------------------
module ov5640_init_sequencer
    import ov5640_init_pkg::*;
#(
    parameter int unsigned CLK_FREQ         = 50_000_000,
    parameter int          ADDR_WIDTH       = 8,
    parameter int          DATA_WIDTH       = 24,
    parameter int          ROM_DEPTH        = 252,
    parameter int          RESET_INDEX      = 1,
    parameter int unsigned POWERUP_DELAY_US = 20000,
    parameter int unsigned RESET_DELAY_US   = 5000,
    parameter int          MAX_RETRY        = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic                  wr_req,
    output logic [15:0]           wr_reg_addr,
    output logic [7:0]            wr_data,
    input  logic                  wr_ack,
    input  logic                  wr_err,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned PWR_CYCLES = us_to_cycles(POWERUP_DELAY_US, CLK_FREQ);
    localparam int unsigned RST_CYCLES = us_to_cycles(RESET_DELAY_US, CLK_FREQ);
    localparam int unsigned MAX_CYCLES = (PWR_CYCLES > RST_CYCLES) ? PWR_CYCLES : RST_CYCLES;
    localparam int CNT_WIDTH   = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);
    localparam int RETRY_WIDTH = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_WIDTH-1:0]   PWR_LOAD  = CNT_WIDTH'(PWR_CYCLES);
    localparam logic [CNT_WIDTH-1:0]   RST_LOAD  = CNT_WIDTH'(RST_CYCLES);
    localparam logic [ADDR_WIDTH-1:0]  LAST_IDX  = ADDR_WIDTH'(ROM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0]  RST_IDX   = ADDR_WIDTH'(RESET_INDEX);
    localparam logic [RETRY_WIDTH-1:0] RETRY_MAX = RETRY_WIDTH'(MAX_RETRY);

    if (longint'(ROM_DEPTH) > (64'sd1 <<< ADDR_WIDTH)) begin : g_depth_check
        $error("ROM_DEPTH does not fit in ADDR_WIDTH");
    end
    if ((CLK_FREQ % 32'd1_000_000) != 0) begin : g_freq_check
        $error("CLK_FREQ must be a multiple of 1 MHz");
    end

    seq_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  index_q, index_d;
    logic [RETRY_WIDTH-1:0] retry_q, retry_d;
    logic                   wr_req_q, wr_req_d;
    logic [15:0]            wr_reg_addr_q, wr_reg_addr_d;
    logic [7:0]             wr_data_q, wr_data_d;

    logic                   tmr_load;
    logic [CNT_WIDTH-1:0]   tmr_load_val;
    logic                   tmr_run;
    logic                   tmr_expired;

    assign tmr_run = (state_q == PWR_WAIT) || (state_q == RST_WAIT);

    ov5640_delay_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_delay_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .run      (tmr_run),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        retry_d       = retry_q;
        wr_req_d      = wr_req_q;
        wr_reg_addr_d = wr_reg_addr_q;
        wr_data_d     = wr_data_q;
        tmr_load      = 1'b0;
        tmr_load_val  = '0;

        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d      = PWR_WAIT;
                    index_d      = '0;
                    retry_d      = '0;
                    tmr_load     = 1'b1;
                    tmr_load_val = PWR_LOAD;
                end
            end
            PWR_WAIT: begin
                if (tmr_expired) state_d = FETCH;
            end
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                wr_reg_addr_d = rom_q[REG_ADDR_MSB:REG_ADDR_LSB];
                wr_data_d     = rom_q[REG_DATA_MSB:REG_DATA_LSB];
                wr_req_d      = 1'b1;
                state_d       = REQ;
            end
            REQ: begin
                // wr_req low while in REQ is the one-cycle gap before a
                // retry; responses are only honoured while requesting.
                if (!wr_req_q) begin
                    wr_req_d = 1'b1;
                end else if (wr_err) begin
                    wr_req_d = 1'b0;
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + RETRY_WIDTH'(1);
                    end else begin
                        state_d = ERROR;
                    end
                end else if (wr_ack) begin
                    wr_req_d = 1'b0;
                    if (index_q == RST_IDX) begin
                        state_d      = RST_WAIT;
                        tmr_load     = 1'b1;
                        tmr_load_val = RST_LOAD;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            RST_WAIT: begin
                if (tmr_expired) state_d = NEXT;
            end
            NEXT: begin
                retry_d = '0;
                if (index_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    index_d = index_q + ADDR_WIDTH'(1);
                    state_d = FETCH;
                end
            end
            default: begin
                state_d  = IDLE;
                wr_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            index_q       <= '0;
            retry_q       <= '0;
            wr_req_q      <= 1'b0;
            wr_reg_addr_q <= '0;
            wr_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            retry_q       <= retry_d;
            wr_req_q      <= wr_req_d;
            wr_reg_addr_q <= wr_reg_addr_d;
            wr_data_q     <= wr_data_d;
        end
    end

    // rom_addr follows the index in every state, so it already points at the
    // failing entry when the sequencer stops in ERROR.
    assign rom_addr    = index_q;
    assign wr_req      = wr_req_q;
    assign wr_reg_addr = wr_reg_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = !((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
    assign done        = (state_q == DONE);
    assign err         = (state_q == ERROR);

endmodule

// File: tb/tb_ov5640_init_sequencer.sv
module tb_ov5640_init_sequencer;

    localparam int unsigned CLK_FREQ  = 1_000_000;
    localparam int unsigned PWR_US    = 10;
    localparam int unsigned RST_US    = 5;
    localparam int          DEPTH     = 6;
    localparam int          RST_IDX   = 1;
    localparam int          MAX_RETRY = 3;
    localparam int          PWR_CYC   = int'(PWR_US * (CLK_FREQ / 1_000_000));
    localparam int          RST_CYC   = int'(RST_US * (CLK_FREQ / 1_000_000));

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rom_addr;
    logic [23:0] rom_q;
    logic        wr_req;
    logic [15:0] wr_reg_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        wr_err;
    logic        busy;
    logic        done;
    logic        err;

    logic [23:0] rom_mem [0:255];
    int          nack_plan [DEPTH];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    // registered ROM, one clk of latency
    always @(posedge clk) rom_q <= rom_mem[rom_addr];

    ov5640_init_sequencer #(
        .CLK_FREQ         (CLK_FREQ),
        .ADDR_WIDTH       (8),
        .DATA_WIDTH       (24),
        .ROM_DEPTH        (DEPTH),
        .RESET_INDEX      (RST_IDX),
        .POWERUP_DELAY_US (PWR_US),
        .RESET_DELAY_US   (RST_US),
        .MAX_RETRY        (MAX_RETRY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .wr_req      (wr_req),
        .wr_reg_addr (wr_reg_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .wr_err      (wr_err),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_req"},   32'(wr_req),      0);
        chk({tag, "_rom_addr"}, 32'(rom_addr),    0);
        chk({tag, "_reg_addr"}, 32'(wr_reg_addr), 0);
        chk({tag, "_data"},     32'(wr_data),     0);
        chk({tag, "_busy"},     32'(busy),        0);
        chk({tag, "_done"},     32'(done),        0);
        chk({tag, "_err"},      32'(err),         0);
    endtask

    // Waits for wr_req to rise while randomly pulsing start, which must be
    // ignored because the sequencer is busy throughout.
    task automatic wait_rise(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            start = ($urandom_range(0, 11) == 0);
            tick();
            if (wr_req) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!ok) chk("wr_req_rise_timeout", 32'(wr_req), 1);
    endtask

    // One full sequence. Expected behaviour follows the sequencing rules:
    // first request PWR_CYC+2 clk after start (wait, FETCH, LATCH), a
    // request 3 clk after an ACK (NEXT, FETCH, LATCH) plus RST_CYC after the
    // reset entry, a retry 1 clk after a NACK, ERROR on the NACK that follows
    // MAX_RETRY retries. abort_at >= 0 applies reset when that entry requests.
    task automatic run_seq(input int abort_at);
        int ref_edge;
        int gap_exp;
        int attempt;
        int hold;
        bit ok;
        bit nack;
        bit saw_req;
        logic [23:0] word;

        start = 1'b1;
        tick();
        start = 1'b0;
        ref_edge = cyc;
        chk("start_busy", 32'(busy), 1);
        chk("start_done_clr", 32'(done), 0);
        chk("start_err_clr", 32'(err), 0);
        gap_exp = PWR_CYC + 2;

        for (int i = 0; i < DEPTH; i++) begin
            word = rom_mem[i[7:0]];
            attempt = 0;
            while (1) begin
                wait_rise(ok);
                if (!ok) return;
                chk("req_gap", 32'(cyc - ref_edge), 32'(gap_exp));
                chk("req_rom_addr", 32'(rom_addr), 32'(i));
                chk("req_reg_addr", 32'(wr_reg_addr), 32'(word[23:8]));
                chk("req_data", 32'(wr_data), 32'(word[7:0]));
                if (i == abort_at) begin
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                    chk_reset_outputs("abort");
                    return;
                end
                hold = $urandom_range(0, 3);
                repeat (hold) begin
                    start = ($urandom_range(0, 3) == 0);
                    tick();
                    chk("req_hold", 32'(wr_req), 1);
                    chk("req_hold_addr", 32'(wr_reg_addr), 32'(word[23:8]));
                    chk("req_hold_data", 32'(wr_data), 32'(word[7:0]));
                end
                start = 1'b0;
                nack = (attempt < nack_plan[i]);
                wr_err = nack;
                wr_ack = !nack || ($urandom_range(0, 1) == 1);
                tick();
                wr_ack = 1'b0;
                wr_err = 1'b0;
                ref_edge = cyc;
                chk("req_drop", 32'(wr_req), 0);
                if (nack) begin
                    if (attempt == MAX_RETRY) begin
                        chk("error_err", 32'(err), 1);
                        chk("error_busy", 32'(busy), 0);
                        chk("error_done", 32'(done), 0);
                        chk("error_rom_addr", 32'(rom_addr), 32'(i));
                        saw_req = 1'b0;
                        repeat (20) begin
                            tick();
                            saw_req |= wr_req;
                        end
                        chk("error_no_req", 32'(saw_req), 0);
                        chk("error_sticky", 32'(err), 1);
                        return;
                    end
                    attempt++;
                    gap_exp = 1;
                end else begin
                    gap_exp = 3 + ((i == RST_IDX) ? RST_CYC : 0);
                    break;
                end
            end
        end
        tick();
        chk("done_done", 32'(done), 1);
        chk("done_busy", 32'(busy), 0);
        chk("done_err", 32'(err), 0);
        chk("done_wr_req", 32'(wr_req), 0);
    endtask

    task automatic clear_plan();
        for (int i = 0; i < DEPTH; i++) nack_plan[i] = 0;
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 256; i++) rom_mem[i] = 24'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        wr_ack = 1'b0;
        wr_err = 1'b0;
        fill_rom();
        rom_mem[1] = 24'h3008_82;
        repeat (3) tick();
        chk_reset_outputs("reset");
        reset = 1'b0;
        tick();
        chk_reset_outputs("idle");

        // clean pass
        clear_plan();
        run_seq(-1);

        // entry 2 NACKed twice, then ACKed
        clear_plan();
        nack_plan[2] = 2;
        run_seq(-1);

        // entry 0 NACKed on every try -> ERROR
        clear_plan();
        nack_plan[0] = MAX_RETRY + 1;
        run_seq(-1);

        // boundary: exactly MAX_RETRY NACKs still completes
        clear_plan();
        nack_plan[DEPTH-1] = MAX_RETRY;
        run_seq(-1);

        // randomized NACK patterns and table contents
        for (int r = 0; r < 8; r++) begin
            fill_rom();
            for (int i = 0; i < DEPTH; i++)
                nack_plan[i] = ($urandom_range(0, 11) == 0) ? MAX_RETRY + 1 : int'($urandom_range(0, 2));
            run_seq(-1);
        end

        // reset in the middle of the request for entry 2, then restart
        clear_plan();
        run_seq(2);
        run_seq(-1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
